display_pager: RTL
==================

// Module: display_pager
// PURPOSE
//  Pages a DATA_W-bit result word (Anubis plaintext/ciphertext block) onto the
//  Basys3 4-digit display, 16 bits (4 hex digits) per page. Sits between the
//  crypto/UART datapath and the 7-seg display multiplexer, driving its
//  enables/digit inputs. Pages advance by button pulse or by an auto-scroll
//  timer, and a page-number marker is shown briefly after every page change.
// PARAMETERS
//  DATA_W        128          width of loaded word; multiple of 16; pages NP = DATA_W/16
//  DWELL_CYCLES  100_000_000  auto-scroll dwell per page in clk cycles (1 s at 100 MHz)
//  MARK_CYCLES   50_000_000   page-marker display time in clk cycles
// PORTS
//  clk         in   1        system clock
//  rst         in   1        synchronous, active-high reset
//  load_valid  in   1        new word offered
//  load_data   in   DATA_W   word to display
//  load_ready  out  1        block accepts a word; transfer when load_valid & load_ready
//  btn_next    in   1        one-cycle pulse (already debounced): next page
//  btn_prev    in   1        one-cycle pulse (already debounced): previous page
//  auto_en     in   1        level: enable auto-scroll
//  page        out  $clog2(NP)  current page index
//  enables     out  4        digit enables to the display mux (bit3 = leftmost digit)
//  digit3..0   out  5 each   display codes: 5'h00-5'h0F hex, 5'h1F blank
// BEHAVIOUR
//  - All outputs registered; a change caused by an input in cycle N is visible in cycle N+1.
//  - Reset: state=EMPTY, page=0, enables=4'b0000, digit3..0=5'h1F, load_ready=0
//    while rst=1; load_ready=1 from the first cycle after rst falls.
//  - load_ready is 1 in every state except during reset; a new load always replaces the
//    buffer, sets page=0, and enters MARK.
//  - Page p shows buffer[DATA_W-1-16p -: 16]; digit3 = MS nibble, digit0 = LS nibble,
//    each zero-extended to 5 bits. Page 0 is the most significant page.
//  - FSM:
//    EMPTY: enables=0000, digits=5'h1F. Buttons/auto ignored. load -> MARK.
//    MARK : enables=0001, digit0={2'b0,page} (page number), digit3..1=5'h1F. mark_cnt counts
//           0..MARK_CYCLES-1, then -> SHOW. Dwell counter held at 0.
//    SHOW : enables=1111, digits = page nibbles. If auto_en=1, dwell_cnt counts
//           0..DWELL_CYCLES-1; at terminal count page advances (+1) -> MARK.
//           auto_en=0 holds dwell_cnt at 0.
//  - Page step (MARK or SHOW): btn_next -> page+1, btn_prev -> page-1, modulo NP
//    (NP-1 -> 0, 0 -> NP-1). Any step resets dwell_cnt and mark_cnt and enters/restarts MARK.
//  - Simultaneous events, priority high->low: rst; load accepted (page=0, MARK, buttons
//    ignored); btn_next & btn_prev together = no step; button step; auto terminal count
//    (a button in the same cycle wins, auto step discarded).
//  - rst mid-MARK/SHOW discards the buffer and returns to EMPTY; no partial display.
//  - Counters are sized for max(DWELL_CYCLES, MARK_CYCLES); no overflow beyond terminal count.
// TESTING  (bench uses DATA_W=128, DWELL_CYCLES=20, MARK_CYCLES=4)
//  1 Reset: rst=1 for 3 cycles -> enables=0000, digits=1F, page=0, load_ready=0;
//    cycle after rst falls load_ready=1.
//  2 Load 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 -> next cycle MARK: enables=0001,
//    digit0=00 for 4 cycles; then SHOW: enables=1111, digits 00,01,02,03.
//  3 In SHOW on page 0 pulse btn_prev -> page=7, MARK digit0=07, then digits 03,02,01,00;
//    btn_next from page 7 -> page=0.
//  4 auto_en=1 in SHOW page 1 -> after exactly 20 SHOW cycles page=2, MARK then 08,09,0A,0B;
//    btn_next on the terminal-count cycle -> page=2 once (auto step discarded).
//  5 btn_next & btn_prev same cycle -> page unchanged; load_valid & btn_next same cycle
//    -> page=0 with new data.
//  6 rst asserted mid-SHOW -> next cycle EMPTY outputs; buttons ignored until a new load.

Source files
------------

// File: rtl/display_pager_if.sv
// Load handshake, page buttons and display-side outputs of the display pager.
// A word transfers on a cycle where load_valid and load_ready are both high; load_data is held with load_valid.
interface display_pager_if #(
  parameter int DATA_W = 128
);
  localparam int NP = DATA_W / 16;
  localparam int PW = (NP > 1) ? $clog2(NP) : 1;

  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              btn_next;
  logic              btn_prev;
  logic              auto_en;
  logic [PW-1:0]     page;
  logic [3:0]        enables;
  logic [4:0]        digit3;
  logic [4:0]        digit2;
  logic [4:0]        digit1;
  logic [4:0]        digit0;
  logic [1:0]        state_dbg;

  modport master (
    output load_valid, load_data, btn_next, btn_prev, auto_en,
    input  load_ready, page, enables, digit3, digit2, digit1, digit0, state_dbg
  );

  modport slave (
    input  load_valid, load_data, btn_next, btn_prev, auto_en,
    output load_ready, page, enables, digit3, digit2, digit1, digit0, state_dbg
  );
endinterface

// File: rtl/display_pager.sv
// Pages a DATA_W-bit word onto a 4-digit 7-seg display, 16 bits per page,
// with button/auto-scroll paging and a transient page-number marker.
module display_pager #(
  parameter int DATA_W       = 128,
  parameter int DWELL_CYCLES = 100_000_000,
  parameter int MARK_CYCLES  = 50_000_000
) (
  input logic           clk,
  input logic           rst,
  display_pager_if.slave bus
);
  localparam int NP    = DATA_W / 16;
  localparam int PW    = (NP > 1) ? $clog2(NP) : 1;
  localparam int MAXC  = (DWELL_CYCLES > MARK_CYCLES) ? DWELL_CYCLES : MARK_CYCLES;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [19:0] BLANK = {4{5'h1F}};

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_MARK  = 2'd1,
    S_SHOW  = 2'd2
  } state_e;

  state_e            state_q;
  logic [PW-1:0]     page_q;
  logic [DATA_W-1:0] buf_q;
  logic [CNT_W-1:0]  mark_cnt_q;
  logic [CNT_W-1:0]  dwell_cnt_q;
  logic [3:0]        enables_q;
  logic [19:0]       digits_q;
  logic              load_ready_q;

  logic              accept;
  logic              btn_step;
  logic              mark_done;
  logic              dwell_done;
  logic [PW-1:0]     page_inc;
  logic [PW-1:0]     page_dec;
  logic [PW-1:0]     page_step_d;

  function automatic logic [19:0] mark_digits(input logic [PW-1:0] p);
    return {BLANK[19:5], 5'(p)};
  endfunction

  function automatic logic [19:0] show_digits(input logic [DATA_W-1:0] b, input logic [PW-1:0] p);
    logic [15:0] w;
    w = 16'(b >> (16 * (NP - 1 - int'(p))));
    return {1'b0, w[15:12], 1'b0, w[11:8], 1'b0, w[7:4], 1'b0, w[3:0]};
  endfunction

  // Both buttons in one cycle cancel; a step always wins over the auto terminal count.
  always_comb begin
    accept      = bus.load_valid & load_ready_q;
    btn_step    = bus.btn_next ^ bus.btn_prev;
    mark_done   = (mark_cnt_q == CNT_W'(MARK_CYCLES - 1));
    dwell_done  = (dwell_cnt_q == CNT_W'(DWELL_CYCLES - 1));
    page_inc    = (page_q == PW'(NP - 1)) ? '0 : page_q + 1'b1;
    page_dec    = (page_q == '0) ? PW'(NP - 1) : page_q - 1'b1;
    page_step_d = bus.btn_next ? page_inc : page_dec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_EMPTY;
      page_q       <= '0;
      buf_q        <= '0;
      mark_cnt_q   <= '0;
      dwell_cnt_q  <= '0;
      enables_q    <= 4'b0000;
      digits_q     <= BLANK;
      load_ready_q <= 1'b0;
    end else begin
      load_ready_q <= 1'b1;
      if (accept) begin
        buf_q       <= bus.load_data;
        page_q      <= '0;
        state_q     <= S_MARK;
        mark_cnt_q  <= '0;
        dwell_cnt_q <= '0;
        enables_q   <= 4'b0001;
        digits_q    <= mark_digits('0);
      end else begin
        case (state_q)
          S_MARK, S_SHOW: begin
            if (btn_step) begin
              page_q      <= page_step_d;
              state_q     <= S_MARK;
              mark_cnt_q  <= '0;
              dwell_cnt_q <= '0;
              enables_q   <= 4'b0001;
              digits_q    <= mark_digits(page_step_d);
            end else if (state_q == S_MARK) begin
              dwell_cnt_q <= '0;
              if (mark_done) begin
                state_q    <= S_SHOW;
                mark_cnt_q <= '0;
                enables_q  <= 4'b1111;
                digits_q   <= show_digits(buf_q, page_q);
              end else begin
                mark_cnt_q <= mark_cnt_q + 1'b1;
              end
            end else if (bus.auto_en) begin
              if (dwell_done) begin
                page_q      <= page_inc;
                state_q     <= S_MARK;
                mark_cnt_q  <= '0;
                dwell_cnt_q <= '0;
                enables_q   <= 4'b0001;
                digits_q    <= mark_digits(page_inc);
              end else begin
                dwell_cnt_q <= dwell_cnt_q + 1'b1;
              end
            end else begin
              dwell_cnt_q <= '0;
            end
          end
          S_EMPTY: begin
          end
          default: begin
            state_q   <= S_EMPTY;
            enables_q <= 4'b0000;
            digits_q  <= BLANK;
          end
        endcase
      end
    end
  end

  assign bus.load_ready = load_ready_q;
  assign bus.page       = page_q;
  assign bus.enables    = enables_q;
  assign bus.digit3     = digits_q[19:15];
  assign bus.digit2     = digits_q[14:10];
  assign bus.digit1     = digits_q[9:5];
  assign bus.digit0     = digits_q[4:0];
  assign bus.state_dbg  = state_q;
endmodule
